// File: rtl/ex_operand_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ex_operand_stage                                           |
// | Description : MIPS ID/EX register with ALU-op decode, operand forwarding |
// |               and load-use stall / bubble insertion.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ex_operand_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic [XLEN-1:0]  id_rs_data,
    input  logic [XLEN-1:0]  id_rt_data,
    input  logic             flush,
    input  logic             exmem_regwrite,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic             memwb_regwrite,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [XLEN-1:0]  memwb_result,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [3:0]       ex_op,
    output logic [4:0]       ex_shamt,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_jr,
    output logic             ex_branch
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_JR  = 4'b0011;
    localparam logic [3:0] c_OP_SLL = 4'b0100;
    localparam logic [3:0] c_OP_SRL = 4'b0101;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;

    localparam logic [5:0] c_OPC_RTYPE = 6'h00;
    localparam logic [5:0] c_OPC_BEQ   = 6'h04;
    localparam logic [5:0] c_OPC_ADDI  = 6'h08;
    localparam logic [5:0] c_OPC_SLTI  = 6'h0A;
    localparam logic [5:0] c_OPC_ANDI  = 6'h0C;
    localparam logic [5:0] c_OPC_ORI   = 6'h0D;
    localparam logic [5:0] c_OPC_LW    = 6'h23;
    localparam logic [5:0] c_OPC_SW    = 6'h2B;

    // Instruction fields
    logic [5:0]       w_opcode;
    logic [5:0]       w_funct;
    logic [RADDR-1:0] w_id_rs;
    logic [RADDR-1:0] w_id_rt;
    logic [RADDR-1:0] w_id_rd;
    logic [4:0]       w_id_shamt;
    logic [15:0]      w_imm;
    logic [XLEN-1:0]  w_imm_sext;
    logic [XLEN-1:0]  w_imm_zext;

    assign w_opcode   = id_instr[31:26];
    assign w_id_rs    = id_instr[25:21];
    assign w_id_rt    = id_instr[20:16];
    assign w_id_rd    = id_instr[15:11];
    assign w_id_shamt = id_instr[10:6];
    assign w_funct    = id_instr[5:0];
    assign w_imm      = id_instr[15:0];
    assign w_imm_sext = {{(XLEN-16){w_imm[15]}}, w_imm};
    assign w_imm_zext = {{(XLEN-16){1'b0}}, w_imm};

    // Decoded ID instruction
    logic             w_dec_valid;
    logic [3:0]       w_dec_op;
    logic [4:0]       w_dec_shamt;
    logic             w_dec_b_is_rt;
    logic [XLEN-1:0]  w_dec_imm;
    logic [RADDR-1:0] w_dec_rd;
    logic             w_dec_regwrite;
    logic             w_dec_memread;
    logic             w_dec_memwrite;
    logic             w_dec_jr;
    logic             w_dec_branch;
    logic             w_reads_rt;

    always_comb begin
        w_dec_valid    = 1'b0;
        w_dec_op       = c_OP_ADD;
        w_dec_shamt    = 5'd0;
        w_dec_b_is_rt  = 1'b0;
        w_dec_imm      = '0;
        w_dec_rd       = '0;
        w_dec_regwrite = 1'b0;
        w_dec_memread  = 1'b0;
        w_dec_memwrite = 1'b0;
        w_dec_jr       = 1'b0;
        w_dec_branch   = 1'b0;
        w_reads_rt     = 1'b0;
        case (w_opcode)
            c_OPC_RTYPE: begin
                w_reads_rt     = 1'b1;
                w_dec_b_is_rt  = 1'b1;
                w_dec_rd       = w_id_rd;
                w_dec_regwrite = 1'b1;
                w_dec_valid    = 1'b1;
                case (w_funct)
                    6'h20, 6'h21: w_dec_op = c_OP_ADD;
                    6'h22, 6'h23: w_dec_op = c_OP_SUB;
                    6'h24:        w_dec_op = c_OP_AND;
                    6'h25:        w_dec_op = c_OP_OR;
                    6'h2A:        w_dec_op = c_OP_SLT;
                    6'h00: begin
                        w_dec_op    = c_OP_SLL;
                        w_dec_shamt = w_id_shamt;
                    end
                    6'h02: begin
                        w_dec_op    = c_OP_SRL;
                        w_dec_shamt = w_id_shamt;
                    end
                    6'h08: begin
                        w_dec_op       = c_OP_JR;
                        w_dec_jr       = 1'b1;
                        w_dec_regwrite = 1'b0;
                        w_dec_rd       = '0;
                    end
                    default:      w_dec_valid = 1'b0;
                endcase
            end
            c_OPC_ADDI: begin
                w_dec_valid = 1'b1; w_dec_op = c_OP_ADD; w_dec_imm = w_imm_sext;
                w_dec_rd = w_id_rt; w_dec_regwrite = 1'b1;
            end
            c_OPC_SLTI: begin
                w_dec_valid = 1'b1; w_dec_op = c_OP_SLT; w_dec_imm = w_imm_sext;
                w_dec_rd = w_id_rt; w_dec_regwrite = 1'b1;
            end
            c_OPC_ANDI: begin
                w_dec_valid = 1'b1; w_dec_op = c_OP_AND; w_dec_imm = w_imm_zext;
                w_dec_rd = w_id_rt; w_dec_regwrite = 1'b1;
            end
            c_OPC_ORI: begin
                w_dec_valid = 1'b1; w_dec_op = c_OP_OR; w_dec_imm = w_imm_zext;
                w_dec_rd = w_id_rt; w_dec_regwrite = 1'b1;
            end
            c_OPC_LW: begin
                w_dec_valid = 1'b1; w_dec_op = c_OP_ADD; w_dec_imm = w_imm_sext;
                w_dec_rd = w_id_rt; w_dec_regwrite = 1'b1; w_dec_memread = 1'b1;
            end
            c_OPC_SW: begin
                w_dec_valid = 1'b1; w_dec_op = c_OP_ADD; w_dec_imm = w_imm_sext;
                w_dec_rd = w_id_rt; w_dec_memwrite = 1'b1; w_reads_rt = 1'b1;
            end
            c_OPC_BEQ: begin
                w_dec_valid = 1'b1; w_dec_op = c_OP_SUB; w_dec_b_is_rt = 1'b1;
                w_dec_rd = w_id_rt; w_dec_branch = 1'b1; w_reads_rt = 1'b1;
            end
            default: w_dec_valid = 1'b0;
        endcase
    end

    // EX-stage registers
    logic             r_valid;
    logic [3:0]       r_op;
    logic [4:0]       r_shamt;
    logic             r_b_is_rt;
    logic [RADDR-1:0] r_rs;
    logic [RADDR-1:0] r_rt;
    logic [XLEN-1:0]  r_rs_data;
    logic [XLEN-1:0]  r_rt_data;
    logic [XLEN-1:0]  r_imm;
    logic [RADDR-1:0] r_rd;
    logic             r_regwrite;
    logic             r_memread;
    logic             r_memwrite;
    logic             r_jr;
    logic             r_branch;

    logic w_stall;
    logic w_load_bubble;

    // The load in EX cannot forward its data until it reaches MEM/WB
    assign w_stall = r_valid && r_memread && (r_rd != '0) && id_valid &&
                     ((r_rd == w_id_rs) || ((r_rd == w_id_rt) && w_reads_rt));

    assign w_load_bubble = flush || w_stall || !id_valid || !w_dec_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_op       <= c_OP_AND;
            r_shamt    <= 5'd0;
            r_b_is_rt  <= 1'b0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_jr       <= 1'b0;
            r_branch   <= 1'b0;
        end else if (w_load_bubble) begin
            r_valid    <= 1'b0;
            r_op       <= c_OP_ADD;
            r_shamt    <= 5'd0;
            r_b_is_rt  <= 1'b0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_jr       <= 1'b0;
            r_branch   <= 1'b0;
        end else begin
            r_valid    <= 1'b1;
            r_op       <= w_dec_op;
            r_shamt    <= w_dec_shamt;
            r_b_is_rt  <= w_dec_b_is_rt;
            r_rs       <= w_id_rs;
            r_rt       <= w_id_rt;
            r_rs_data  <= id_rs_data;
            r_rt_data  <= id_rt_data;
            r_imm      <= w_dec_imm;
            r_rd       <= w_dec_rd;
            r_regwrite <= w_dec_regwrite && (w_dec_rd != '0);
            r_memread  <= w_dec_memread;
            r_memwrite <= w_dec_memwrite;
            r_jr       <= w_dec_jr;
            r_branch   <= w_dec_branch;
        end
    end

    // Forwarding: EX/MEM wins over MEM/WB; register $0 never forwards
    logic [XLEN-1:0] w_fwd_rs;
    logic [XLEN-1:0] w_fwd_rt;

    always_comb begin
        w_fwd_rs = r_rs_data;
        if (r_valid && exmem_regwrite && (exmem_rd == r_rs) && (r_rs != '0))
            w_fwd_rs = exmem_result;
        else if (r_valid && memwb_regwrite && (memwb_rd == r_rs) && (r_rs != '0))
            w_fwd_rs = memwb_result;
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        if (r_valid && exmem_regwrite && (exmem_rd == r_rt) && (r_rt != '0))
            w_fwd_rt = exmem_result;
        else if (r_valid && memwb_regwrite && (memwb_rd == r_rt) && (r_rt != '0))
            w_fwd_rt = memwb_result;
    end

    assign id_stall      = w_stall;
    assign ex_valid      = r_valid;
    assign ex_op         = r_op;
    assign ex_shamt      = r_shamt;
    assign ex_a          = w_fwd_rs;
    assign ex_b          = r_b_is_rt ? w_fwd_rt : r_imm;
    assign ex_store_data = w_fwd_rt;
    assign ex_rd         = r_rd;
    assign ex_regwrite   = r_regwrite;
    assign ex_memread    = r_memread;
    assign ex_memwrite   = r_memwrite;
    assign ex_jr         = r_jr;
    assign ex_branch     = r_branch;

endmodule
`default_nettype wire
